moving_average_sched: RTL
=========================

MOVING_AVERAGE_SCHED -- requirements
Module: moving_average_sched

Interface
REQ-001 SHALL have parameter DATA_WD, default 16, sample and result width (signed two's complement).
REQ-002 SHALL have parameter NUM_CH, default 4, number of requesting channels (power of 2, >=2).
REQ-003 SHALL have parameter WIN_LOG2, default 2, log2 of averaging window (window = 4 samples).
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  input  NUM_CH  per-channel sample-valid request.
REQ-007 SHALL have port i_data  input  NUM_CH x DATA_WD  per-channel signed sample.
REQ-008 SHALL have port o_ready  output  NUM_CH  per-channel accept strobe; at most one bit high.
REQ-009 SHALL have port i_flush  input  1  synchronous clear of all channel histories.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port o_ch  output  log2(NUM_CH)  channel id of result.
REQ-012 SHALL have port o_data  output  DATA_WD  signed windowed average.
REQ-013 SHALL have port i_ready  input  1  downstream accept of result.

Function
REQ-014 SHALL time-share one accumulate/average datapath across all channels; at most one sample accepted per cycle.
REQ-015 SHALL set slot_free = !o_valid || i_ready; no grant when slot_free is 0 or i_flush is 1.
REQ-016 SHALL grant round-robin: search i_valid starting at pointer rr_ptr, wrapping NUM_CH-1 -> 0; o_ready is one-hot of the granted channel, combinational from i_valid, rr_ptr, slot_free.
REQ-017 SHALL treat a sample as accepted in the cycle i_valid[c] && o_ready[c]; after accept rr_ptr = c+1 mod NUM_CH; otherwise rr_ptr holds.
REQ-018 SHALL keep per channel a WIN-deep sample history (reset 0) and running sum of DATA_WD+WIN_LOG2 bits (reset 0).
REQ-019 SHALL on accept compute sum_new = sum - oldest + new, shift new into history, drop oldest, store sum_new.
REQ-020 SHALL produce average = sum_new arithmetic-shifted right WIN_LOG2 (floor toward -inf), truncated to DATA_WD; no overflow possible.
REQ-021 SHALL register result: o_valid=1, o_ch=c, o_data=average on the edge after accept (latency 1 cycle).
REQ-022 SHALL hold o_valid, o_ch, o_data stable while o_valid && !i_ready; clear o_valid after i_ready when no new accept that cycle.
REQ-023 SHALL allow back-to-back accepts every cycle while i_ready stays 1 (full throughput).
REQ-024 SHALL on i_flush zero all histories and sums at next edge; a pending o_valid result is unaffected and still delivered; rr_ptr unaffected.
REQ-025 SHALL leave a channel that never wins untouched; a channel with i_valid held waits at most NUM_CH-1 accepts.

Reset
REQ-026 SHALL on i_rst asynchronously set o_valid=0, o_ch=0, o_data=0, rr_ptr=0, all histories and sums 0; o_ready is all 0 while i_rst is high.
REQ-027 SHALL discard any in-flight result when reset is asserted mid-operation; first post-reset result uses zeroed history.

Structure
REQ-028 SHALL place DATA_WD, NUM_CH, WIN_LOG2 defaults, derived SUM_WD and channel-id typedef in package moving_average_pkg.
REQ-029 SHALL implement the round-robin grant as sub-module rr_arbiter (request vector, pointer -> one-hot grant, grant index, any-grant).
REQ-030 SHALL keep histories and sums in the top module, indexed by grant index.

Verification
REQ-031 SHALL check ch0 samples 4,8,12,16,20 with i_ready=1 -> o_data 1,3,6,10,14, o_ch=0, one cycle after each accept.
REQ-032 SHALL check ch1 single sample -3 from reset -> o_data -1 (floor); then -8 -> sum -11 -> o_data -3.
REQ-033 SHALL check all four i_valid held high, i_ready=1 -> grants ch0,1,2,3,0,1 on consecutive cycles, o_ready one-hot every cycle.
REQ-034 SHALL check i_ready low 3 cycles with o_valid=1 -> o_valid/o_ch/o_data stable, o_ready all 0; accept resumes the cycle i_ready returns.
REQ-035 SHALL check i_flush after ch2 samples 100,100 then sample 40 -> o_data 10 (history cleared), not 60.
REQ-036 SHALL check i_rst pulse mid-stream with o_valid=1 -> o_valid 0 immediately, rr_ptr 0, next ch0 sample 8 -> o_data 2.

Source files
------------

// File: rtl/moving_average_pkg.sv
// Shared defaults and types for the time-shared moving-average block.
// Contents: default widths/window, derived running-sum width, channel-id type.
package moving_average_pkg;

  localparam int DEF_DATA_WD  = 16;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_WIN_LOG2 = 2;

  // Sum of 2**WIN_LOG2 DATA_WD-bit samples needs WIN_LOG2 extra bits.
  localparam int DEF_SUM_WD   = DEF_DATA_WD + DEF_WIN_LOG2;

  typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first request at or after ptr (wrapping) wins.
// Ports: req (request vector), ptr (search start) -> gnt (one-hot),
//        gnt_idx (winner index), gnt_any (some request granted). Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // N is a power of two, so the IW-bit add wraps N-1 -> 0 for free.
      idx = ptr + IW'(i);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/moving_average_sched.sv
// Multi-channel windowed moving average sharing one accumulate datapath.
// Ports: i_valid/i_data/o_ready per-channel sample handshake, i_flush clears
//        histories, o_valid/o_ch/o_data/i_ready registered result (1-cycle latency).
module moving_average_sched
  import moving_average_pkg::*;
#(
  parameter int DATA_WD  = DEF_DATA_WD,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_CH-1:0]               i_valid,
  input  logic [NUM_CH-1:0][DATA_WD-1:0]  i_data,
  output logic [NUM_CH-1:0]               o_ready,
  input  logic                            i_flush,
  output logic                            o_valid,
  output logic [$clog2(NUM_CH)-1:0]       o_ch,
  output logic [DATA_WD-1:0]              o_data,
  input  logic                            i_ready
);

  localparam int SUM_WD = DATA_WD + WIN_LOG2;
  localparam int WIN    = 1 << WIN_LOG2;
  localparam int CH_WD  = $clog2(NUM_CH);

  logic signed [DATA_WD-1:0] hist [NUM_CH][WIN];
  logic signed [SUM_WD-1:0]  sum  [NUM_CH];
  logic [CH_WD-1:0]          rr_ptr;

  logic              slot_free;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_WD-1:0]  gnt_idx;
  logic              gnt_any;

  logic signed [DATA_WD-1:0] new_s;
  logic signed [DATA_WD-1:0] old_s;
  logic signed [SUM_WD-1:0]  sum_new;
  logic signed [SUM_WD-1:0]  avg_full;

  // A grant is only offered when the output register can take the result.
  assign slot_free = !o_valid || i_ready;
  assign req       = (slot_free && !i_flush && !i_rst) ? i_valid : '0;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (CH_WD)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign o_ready = gnt;

  // Grant is only given to a requesting channel, so gnt_any means accept.
  always_comb begin
    new_s    = $signed(i_data[gnt_idx]);
    old_s    = hist[gnt_idx][WIN-1];
    sum_new  = sum[gnt_idx]
             - $signed({{WIN_LOG2{old_s[DATA_WD-1]}}, old_s})
             + $signed({{WIN_LOG2{new_s[DATA_WD-1]}}, new_s});
    // Arithmetic shift floors toward -inf; result always fits DATA_WD.
    avg_full = sum_new >>> WIN_LOG2;
  end

  // Channel histories and running sums.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        for (int k = 0; k < WIN; k++) hist[c][k] <= '0;
      end
    end else if (i_flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        for (int k = 0; k < WIN; k++) hist[c][k] <= '0;
      end
    end else if (gnt_any) begin
      sum[gnt_idx]     <= sum_new;
      hist[gnt_idx][0] <= new_s;
      for (int k = 1; k < WIN; k++) hist[gnt_idx][k] <= hist[gnt_idx][k-1];
    end
  end

  // Round-robin pointer and registered result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr  <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_data  <= '0;
    end else if (gnt_any) begin
      rr_ptr  <= gnt_idx + 1'b1;
      o_valid <= 1'b1;
      o_ch    <= gnt_idx;
      o_data  <= avg_full[DATA_WD-1:0];
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
